alveo_reset_sequencer: RTL and testbench

Post-clocking reset sequencer for the Alveo board infrastructure. It runs in the `sys_clk` domain, downstream of the MMCM and IDELAYCTRL. It waits for MMCM lock and IDELAYCTRL ready, then releases `N_STAGES` downstream reset domains one at a time (for example: DRAM, Ethernet core, user fabric). Each release waits for that stage's ready acknowledgement and then a programmable settle gap. It re-sequences from scratch on lock loss or a software reset request.

---
 rtl/alveo_reset_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_alveo_reset_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alveo_reset_sequencer.sv
// -----------------------------------------------------------------------------
// alveo_reset_sequencer
//
// Post-clocking reset sequencer in the sys_clk domain. It holds every
// downstream reset domain in reset for a minimum hold time and then waits for
// MMCM lock and IDELAYCTRL ready. After that it releases the domains one at a
// time. Each release waits for that stage's ready acknowledgement and then a
// settle gap. Loss of lock or a software request re-sequences from scratch.
//
// Optional feature macro: RST_SEQ_TIMEOUT_EN
//   defined   - WAIT_RDY is bounded by TIMEOUT_CYCLES. On expiry the sequencer
//               parks in ERROR, reporting the stage index on fault_stage.
//   undefined - WAIT_RDY waits forever; seq_error/fault_stage are tied to 0.
//
// Ports
//   sys_clk       in   sequencer clock
//   sys_rst       in   synchronous active-high reset
//   pll_lock      in   MMCM LOCKED (async, 2-flop synchronised)
//   idelay_rdy    in   IDELAYCTRL RDY (async, 2-flop synchronised)
//   stage_rdy     in   per-stage ready acknowledgement (async, per-bit sync)
//   sw_reset_req  in   one-cycle pulse requesting a full re-sequence
//   rst_out       out  active-high reset per stage (registered)
//   seq_done      out  all stages released and ready (registered)
//   seq_error     out  stage timeout latched (registered)
//   fault_stage   out  index of the timed-out stage (registered)
// -----------------------------------------------------------------------------
module alveo_reset_sequencer #(
    parameter int N_STAGES       = 4,
    parameter int HOLD_CYCLES    = 1024,
    parameter int GAP_CYCLES     = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                pll_lock,
    input  logic                idelay_rdy,
    input  logic [N_STAGES-1:0] stage_rdy,
    input  logic                sw_reset_req,
    output logic [N_STAGES-1:0] rst_out,
    output logic                seq_done,
    output logic                seq_error,
    output logic [2:0]          fault_stage
);

    localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_HG > TIMEOUT_CYCLES) ? CNT_MAX_HG : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int HOLD_LAST  = HOLD_CYCLES - 1;
    // GAP_LAST is only consulted when GAP_CYCLES > 0; the guard keeps it non-negative.
    localparam int GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int TO_LAST    = TIMEOUT_CYCLES - 1;
`endif
    localparam logic [2:0] LAST_STAGE = 3'(N_STAGES - 1);

    typedef enum logic [2:0] {
        ST_HOLD        = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_WAIT_IDELAY = 3'd2,
        ST_WAIT_RDY    = 3'd3,
        ST_GAP         = 3'd4,
        ST_DONE        = 3'd5,
        ST_ERROR       = 3'd6
    } state_t;

    // One-hot selector for stage idx; out-of-range indices select nothing.
    function automatic logic [N_STAGES-1:0] stage_mask(input logic [2:0] idx);
        logic [N_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            m[i] = (3'(i) == idx);
        end
        return m;
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          k;
    logic                pll_meta, pll_sync;
    logic                idl_meta, idl_sync;
    logic [N_STAGES-1:0] rdy_meta, rdy_sync;
    logic                restart_s;
    logic                stage_hit_s;

    // Two-flop synchronisers for the asynchronous status inputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pll_meta <= 1'b0;
            pll_sync <= 1'b0;
            idl_meta <= 1'b0;
            idl_sync <= 1'b0;
            rdy_meta <= '0;
            rdy_sync <= '0;
        end else begin
            pll_meta <= pll_lock;
            pll_sync <= pll_meta;
            idl_meta <= idelay_rdy;
            idl_sync <= idl_meta;
            rdy_meta <= stage_rdy;
            rdy_sync <= rdy_meta;
        end
    end

    // Restart request: software pulse, or lock loss outside HOLD. ERROR is
    // excluded so a timed-out sequence stays parked until software clears it.
    always_comb begin
        restart_s   = sw_reset_req |
                      (~pll_sync & (state != ST_HOLD) & (state != ST_ERROR));
        stage_hit_s = |(rdy_sync & stage_mask(k));
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || restart_s) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            k        <= 3'd0;
            rst_out  <= '1;
            seq_done <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            seq_error   <= 1'b0;
            fault_stage <= 3'd0;
`endif
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == CNT_W'(HOLD_LAST)) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    cnt <= '0;
                    if (pll_sync) begin
                        state <= ST_WAIT_IDELAY;
                    end else begin
                        state <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_IDELAY: begin
                    cnt <= '0;
                    if (idl_sync) begin
                        rst_out <= rst_out & ~stage_mask(k);
                        state   <= ST_WAIT_RDY;
                    end else begin
                        state <= ST_WAIT_IDELAY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (stage_hit_s) begin
                        cnt <= '0;
                        if (k == LAST_STAGE) begin
                            state    <= ST_DONE;
                            rst_out  <= '0;
                            seq_done <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            // No settle gap: release the next stage right away.
                            rst_out <= rst_out & ~stage_mask(k + 3'd1);
                            k       <= k + 3'd1;
                        end else begin
                            state <= ST_GAP;
                        end
`ifdef RST_SEQ_TIMEOUT_EN
                    end else if (cnt == CNT_W'(TO_LAST)) begin
                        state       <= ST_ERROR;
                        cnt         <= '0;
                        rst_out     <= '1;
                        seq_done    <= 1'b0;
                        seq_error   <= 1'b1;
                        fault_stage <= k;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`else
                    end else begin
                        cnt <= '0;
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(GAP_LAST)) begin
                        rst_out <= rst_out & ~stage_mask(k + 3'd1);
                        k       <= k + 3'd1;
                        cnt     <= '0;
                        state   <= ST_WAIT_RDY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Later drops of stage_rdy are deliberately ignored here.
                    state    <= ST_DONE;
                    rst_out  <= '0;
                    seq_done <= 1'b1;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                ST_ERROR: begin
                    state    <= ST_ERROR;
                    rst_out  <= '1;
                    seq_done <= 1'b0;
                end
`endif
                default: begin
                    state    <= ST_HOLD;
                    cnt      <= '0;
                    k        <= 3'd0;
                    rst_out  <= '1;
                    seq_done <= 1'b0;
                end
            endcase
        end
    end

`ifndef RST_SEQ_TIMEOUT_EN
    assign seq_error   = 1'b0;
    assign fault_stage = 3'd0;
`endif

endmodule

// File: tb/tb_alveo_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for alveo_reset_sequencer. Two instances share sys_rst, pll_lock and
// idelay_rdy: dut_a (GAP=4, stages answer 10 cycles after release) and dut_b
// (GAP=0, stages answer immediately). Expected output values are pushed to a
// per-instance queue, keyed by cycle number, as stimulus is applied. A
// negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_alveo_reset_sequencer;

    logic       clk = 1'b0;
    logic       sys_rst, pll_lock, idelay_rdy, sw_a, sw_b;
    logic [3:0] rdy_a = 4'h0;
    logic [3:0] rdy_b = 4'h0;
    logic [3:0] mask_a;
    logic [3:0] stage_rdy_a, stage_rdy_b;
    logic [3:0] rst_a, rst_b;
    logic       done_a, done_b, err_a, err_b;
    logic [2:0] fault_a, fault_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_a [4];
    int cnt_b [4];

    typedef struct {
        int         cyc;
        logic [8:0] val;
        string      tag;
    } sb_item_t;

    sb_item_t qa [$];
    sb_item_t qb [$];
    sb_item_t it_m;

    assign stage_rdy_a = rdy_a & ~mask_a;
    assign stage_rdy_b = rdy_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alveo_reset_sequencer #(.N_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_a (
        .sys_clk(clk), .sys_rst(sys_rst), .pll_lock(pll_lock), .idelay_rdy(idelay_rdy),
        .stage_rdy(stage_rdy_a), .sw_reset_req(sw_a), .rst_out(rst_a),
        .seq_done(done_a), .seq_error(err_a), .fault_stage(fault_a));

    alveo_reset_sequencer #(.N_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut_b (
        .sys_clk(clk), .sys_rst(sys_rst), .pll_lock(pll_lock), .idelay_rdy(idelay_rdy),
        .stage_rdy(stage_rdy_b), .sw_reset_req(sw_b), .rst_out(rst_b),
        .seq_done(done_b), .seq_error(err_b), .fault_stage(fault_b));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [8:0] exp_val(input logic [3:0] r, input logic d,
                                           input logic e, input logic [2:0] f);
        return {f, e, d, r};
    endfunction

    // Sorted insert so the monitor only ever needs to look at the queue head.
    task automatic sb_push(input bit to_b, input int c, input logic [8:0] v, input string tag);
        sb_item_t it;
        int pos;
        it.cyc = c;
        it.val = v;
        it.tag = tag;
        if (!to_b) begin
            pos = qa.size();
            for (int i = qa.size() - 1; i >= 0; i--) if (qa[i].cyc > c) pos = i;
            qa.insert(pos, it);
        end else begin
            pos = qb.size();
            for (int i = qb.size() - 1; i >= 0; i--) if (qb[i].cyc > c) pos = i;
            qb.insert(pos, it);
        end
    endtask

    // HOLD entered at edge h: all resets held through the lock/idelay steps.
    task automatic push_hold(input bit to_b, input int h, input string tag);
        sb_push(to_b, h,      exp_val(4'hF, 1'b0, 1'b0, 3'd0), {tag, "_hold"});
        sb_push(to_b, h + 17, exp_val(4'hF, 1'b0, 1'b0, 3'd0), {tag, "_hold_end"});
    endtask

    // Full release sequence: stage 0 falls at e0, spacing sp, done doff after stage 3.
    task automatic push_seq(input bit to_b, input int e0, input int sp, input int doff, input string tag);
        logic [3:0] prev;
        logic [3:0] nxt;
        int e;
        prev = 4'hF;
        for (int i = 0; i < 4; i++) begin
            nxt = prev << 1;
            e   = e0 + i * sp;
            sb_push(to_b, e - 1, exp_val(prev, 1'b0, 1'b0, 3'd0), $sformatf("%s_pre%0d", tag, i));
            sb_push(to_b, e,     exp_val(nxt,  1'b0, 1'b0, 3'd0), $sformatf("%s_rel%0d", tag, i));
            prev = nxt;
        end
        e = e0 + 3 * sp + doff;
        sb_push(to_b, e - 1, exp_val(4'h0, 1'b0, 1'b0, 3'd0), {tag, "_predone"});
        sb_push(to_b, e,     exp_val(4'h0, 1'b1, 1'b0, 3'd0), {tag, "_done"});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stage responders: raise stage_rdy[i] a fixed delay after rst_out[i] falls.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rst_a[i] !== 1'b0) begin
                rdy_a[i] = 1'b0;
                cnt_a[i] = 0;
            end else if (!rdy_a[i]) begin
                if (cnt_a[i] == 10) rdy_a[i] = 1'b1;
                else cnt_a[i]++;
            end
            if (rst_b[i] !== 1'b0) begin
                rdy_b[i] = 1'b0;
                cnt_b[i] = 0;
            end else if (!rdy_b[i]) begin
                if (cnt_b[i] == 0) rdy_b[i] = 1'b1;
                else cnt_b[i]++;
            end
        end
    end

    // Scoreboard monitor: compare each queued expectation on its cycle.
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            it_m = qa.pop_front();
            if (it_m.cyc == cyc) check_val({"a_", it_m.tag}, {23'd0, fault_a, err_a, done_a, rst_a}, {23'd0, it_m.val});
            else check_val({"a_", it_m.tag, "_late"}, cyc, it_m.cyc);
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            it_m = qb.pop_front();
            if (it_m.cyc == cyc) check_val({"b_", it_m.tag}, {23'd0, fault_b, err_b, done_b, rst_b}, {23'd0, it_m.val});
            else check_val({"b_", it_m.tag, "_late"}, cyc, it_m.cyc);
        end
    end

    initial begin
        sys_rst    = 1'b1;
        pll_lock   = 1'b1;
        idelay_rdy = 1'b1;
        sw_a       = 1'b0;
        sw_b       = 1'b0;
        mask_a     = 4'h0;

        // Reset values.
        wait_cyc(3);
        check_val("reset_a", {23'd0, fault_a, err_a, done_a, rst_a}, {23'd0, exp_val(4'hF, 1'b0, 1'b0, 3'd0)});
        check_val("reset_b", {23'd0, fault_b, err_b, done_b, rst_b}, {23'd0, exp_val(4'hF, 1'b0, 1'b0, 3'd0)});

        // Nominal sequence; last reset edge is 5, so HOLD starts at 5.
        wait_cyc(5);
        sys_rst = 1'b0;
        push_hold(1'b0, 5, "nom");
        push_seq(1'b0, 23, 17, 13, "nom");
        push_hold(1'b1, 5, "nom");
        push_seq(1'b1, 23, 3, 3, "nom");

        // One-cycle lock drop while both are in DONE.
        wait_cyc(95);
        pll_lock = 1'b0;
        sb_push(1'b0, 97, exp_val(4'h0, 1'b1, 1'b0, 3'd0), "lock_pre");
        sb_push(1'b0, 98, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "lock_loss");
        push_hold(1'b0, 98, "lock");
        sb_push(1'b0, 116, exp_val(4'hE, 1'b0, 1'b0, 3'd0), "lock_rel0");
        sb_push(1'b0, 132, exp_val(4'hE, 1'b0, 1'b0, 3'd0), "lock_pre1");
        sb_push(1'b0, 133, exp_val(4'hC, 1'b0, 1'b0, 3'd0), "lock_rel1");
        sb_push(1'b0, 147, exp_val(4'hC, 1'b0, 1'b0, 3'd0), "gap_pre_sw");
        sb_push(1'b1, 97, exp_val(4'h0, 1'b1, 1'b0, 3'd0), "lock_pre");
        sb_push(1'b1, 98, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "lock_loss");
        push_hold(1'b1, 98, "lock");
        push_seq(1'b1, 116, 3, 3, "lock");
        wait_cyc(96);
        pll_lock = 1'b1;

        // Software reset in dut_a's stage-1 gap.
        wait_cyc(147);
        sw_a = 1'b1;
        sb_push(1'b0, 148, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "sw_gap");
        push_hold(1'b0, 148, "sw");
        sb_push(1'b0, 166, exp_val(4'hE, 1'b0, 1'b0, 3'd0), "sw_rel0");
        sb_push(1'b0, 182, exp_val(4'hE, 1'b0, 1'b0, 3'd0), "sw_pre1");
        sb_push(1'b0, 183, exp_val(4'hC, 1'b0, 1'b0, 3'd0), "sw_rel1");
        sb_push(1'b0, 189, exp_val(4'hC, 1'b0, 1'b0, 3'd0), "sysrst_pre");
        wait_cyc(148);
        sw_a = 1'b0;

        // sys_rst mid-sequence, then idelay_rdy held low past the hold.
        wait_cyc(189);
        sys_rst    = 1'b1;
        idelay_rdy = 1'b0;
        sb_push(1'b0, 190, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "sysrst");
        sb_push(1'b1, 189, exp_val(4'h0, 1'b1, 1'b0, 3'd0), "sysrst_pre");
        sb_push(1'b1, 190, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "sysrst");
        wait_cyc(192);
        sys_rst = 1'b0;
        push_hold(1'b0, 192, "idl");
        sb_push(1'b0, 227, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "idl_wait");
        push_seq(1'b0, 228, 17, 13, "idl");
        push_hold(1'b1, 192, "idl");
        sb_push(1'b1, 227, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "idl_wait");
        push_seq(1'b1, 228, 3, 3, "idl");
        wait_cyc(225);
        idelay_rdy = 1'b1;

        // stage_rdy dropping in DONE is ignored.
        wait_cyc(295);
        mask_a = 4'hF;
        sb_push(1'b0, 301, exp_val(4'h0, 1'b1, 1'b0, 3'd0), "done_drop");
        wait_cyc(301);
        mask_a = 4'h0;

`ifdef RST_SEQ_TIMEOUT_EN
        // Stage 2 never answers: timeout after 20 cycles in WAIT_RDY.
        wait_cyc(305);
        sw_a   = 1'b1;
        mask_a = 4'b0100;
        sb_push(1'b0, 306, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "to_hold");
        sb_push(1'b0, 324, exp_val(4'hE, 1'b0, 1'b0, 3'd0), "to_rel0");
        sb_push(1'b0, 341, exp_val(4'hC, 1'b0, 1'b0, 3'd0), "to_rel1");
        sb_push(1'b0, 358, exp_val(4'h8, 1'b0, 1'b0, 3'd0), "to_rel2");
        sb_push(1'b0, 377, exp_val(4'h8, 1'b0, 1'b0, 3'd0), "to_pre");
        sb_push(1'b0, 378, exp_val(4'hF, 1'b0, 1'b1, 3'd2), "to_error");
        wait_cyc(306);
        sw_a = 1'b0;
        wait_cyc(380);
        pll_lock = 1'b0;
        sb_push(1'b0, 387, exp_val(4'hF, 1'b0, 1'b1, 3'd2), "to_lock_ign");
        sb_push(1'b1, 382, exp_val(4'h0, 1'b1, 1'b0, 3'd0), "to_lock_pre");
        sb_push(1'b1, 383, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "to_lock_loss");
        push_hold(1'b1, 383, "to_lock");
        push_seq(1'b1, 401, 3, 3, "to_lock");
        wait_cyc(381);
        pll_lock = 1'b1;
        wait_cyc(390);
        sw_a = 1'b1;
        sb_push(1'b0, 390, exp_val(4'hF, 1'b0, 1'b1, 3'd2), "to_err_hold");
        sb_push(1'b0, 391, exp_val(4'hF, 1'b0, 1'b0, 3'd0), "to_clear");
        wait_cyc(391);
        sw_a   = 1'b0;
        mask_a = 4'h0;
`endif

        wait_cyc(425);
        check_val("sb_left_a", qa.size(), 32'd0);
        check_val("sb_left_b", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
